// File: rtl/code_sel_pkg.sv
// Shared types and sizing for the code-slot allocator.
package code_sel_pkg;
   localparam int N_CODES = 18;
   localparam int CODE_W  = 6;
   localparam int CNT_W   = $clog2(N_CODES + 1);

   typedef logic [CODE_W-1:0]  code_t;
   typedef logic [N_CODES-1:0] mask_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/code_pool_arbiter_if.sv
// Request/grant, release and status bundle of the code-pool allocator.
interface code_pool_arbiter_if
   import code_sel_pkg::*;
#(
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0] req_i;
   logic [N_REQ-1:0] gnt_o;
   code_t            code_o;
   logic             free_val_i;
   code_t            free_code_i;
   logic             free_err_o;
   mask_t            status_o;
   logic             full_o;
   logic             empty_o;
   cnt_t             cnt_o;

   modport master (
      output req_i, free_val_i, free_code_i,
      input  gnt_o, code_o, free_err_o, status_o, full_o, empty_o, cnt_o
   );

   modport slave (
      input  req_i, free_val_i, free_code_i,
      output gnt_o, code_o, free_err_o, status_o, full_o, empty_o, cnt_o
   );
endinterface

// File: rtl/code_pool_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic [IDX_W-1:0] idx
);
   logic             found;
   logic [IDX_W-1:0] sel;

   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      sel    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel = IDX_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[sel]) begin
            found       = 1'b1;
            winner[sel] = 1'b1;
            idx         = sel;
         end
      end
   end
endmodule

// File: rtl/code_pool_arbiter.sv
// Owns the code allocation mask: grants the lowest free code to a round-robin
// winner and accepts releases in any state.
module code_pool_arbiter
   import code_sel_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input logic                clk_i,
   input logic                rst_i,
   code_pool_arbiter_if.slave bus
);
   // state | meaning
   // IDLE  | arbitrate: grant lowest free code if any request and not full
   // GRANT | grant visible for one cycle; allocation committed at its closing edge

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   code_t            code_q, code_d;
   logic [IDX_W-1:0] win_q, win_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   mask_t            status_q, status_d;
   cnt_t             cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] arb_onehot;
   logic [IDX_W-1:0] arb_idx;
   code_t            low_code;
   logic             rel_hit;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req    (bus.req_i),
      .ptr    (ptr_q),
      .winner (arb_onehot),
      .idx    (arb_idx)
   );

   always_comb begin
      low_code = '0;
      for (int k = N_CODES - 1; k >= 0; k--) begin
         if (!status_q[k]) low_code = CODE_W'(k + 1);
      end
   end

   // Codes 0 and above N_CODES never match, so they fall out as invalid.
   always_comb begin
      rel_hit = 1'b0;
      for (int k = 0; k < N_CODES; k++) begin
         if (bus.free_code_i == CODE_W'(k + 1) && status_q[k]) rel_hit = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      code_d   = '0;
      win_d    = win_q;
      ptr_d    = ptr_q;
      status_d = status_q;
      err_d    = 1'b0;
      cnt_d    = '0;

      case (state_q)
         IDLE: begin
            if (|bus.req_i && !full_q) begin
               gnt_d   = arb_onehot;
               code_d  = low_code;
               win_d   = arb_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            for (int k = 0; k < N_CODES; k++) begin
               if (code_q == CODE_W'(k + 1)) status_d[k] = 1'b1;
            end
            ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A release never targets the bit being set: the granted code was free.
      if (bus.free_val_i) begin
         if (rel_hit) begin
            for (int k = 0; k < N_CODES; k++) begin
               if (bus.free_code_i == CODE_W'(k + 1)) status_d[k] = 1'b0;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      for (int k = 0; k < N_CODES; k++) cnt_d = cnt_d + cnt_t'(status_d[k]);
      full_d  = (status_d == '1);
      empty_d = (status_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         code_q   <= '0;
         win_q    <= '0;
         ptr_q    <= '0;
         status_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         code_q   <= code_d;
         win_q    <= win_d;
         ptr_q    <= ptr_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         err_q    <= err_d;
      end
   end

   assign bus.gnt_o      = gnt_q;
   assign bus.code_o     = code_q;
   assign bus.free_err_o = err_q;
   assign bus.status_o   = status_q;
   assign bus.cnt_o      = cnt_q;
   assign bus.full_o     = full_q;
   assign bus.empty_o    = empty_q;
endmodule

// File: tb/tb_code_pool_arbiter.sv
// Scoreboard bench for code_pool_arbiter: expected grants are queued when
// requests are raised and checked by a monitor when gnt_o appears.
module tb_code_pool_arbiter;
   import code_sel_pkg::*;

   typedef struct {
      logic [3:0] gnt;
      code_t      code;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   exp_t e;
   bit   prev_gnt = 0;

   code_pool_arbiter_if #(.N_REQ(4)) bus ();

   code_pool_arbiter #(.N_REQ(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         if (|bus.gnt_o) begin
            if (prev_gnt) begin
               checks++;
               errors++;
               $display("FAIL grant_width: gnt_o=%b high for a second cycle", bus.gnt_o);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_grant: gnt_o=%b code_o=%0d, none expected", bus.gnt_o, bus.code_o);
            end else begin
               e = exp_q.pop_front();
               if (bus.gnt_o !== e.gnt || bus.code_o !== e.code) begin
                  errors++;
                  $display("FAIL grant: got gnt=%b code=%0d, want gnt=%b code=%0d",
                           bus.gnt_o, bus.code_o, e.gnt, e.code);
               end
            end
         end else if (prev_gnt) begin
            checks++;
            if (bus.code_o !== '0) begin
               errors++;
               $display("FAIL code_idle: code_o=%0d after grant, want 0", bus.code_o);
            end
         end
         prev_gnt = |bus.gnt_o;
      end else begin
         prev_gnt = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [3:0] g, input int c);
      exp_t x;
      x.gnt  = g;
      x.code = CODE_W'(c);
      exp_q.push_back(x);
   endtask

   task automatic wait_grant(input int idx, input int max_cyc);
      bit ok = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (bus.gnt_o[idx]) begin
            ok = 1;
            bus.req_i[idx] = 1'b0;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         bus.req_i[idx] = 1'b0;
         $display("FAIL grant_timeout: req%0d got no grant in %0d cycles", idx, max_cyc);
      end
   endtask

   task automatic alloc(input int idx, input int code);
      bus.req_i[idx] = 1'b1;
      push_exp(4'(1 << idx), code);
      wait_grant(idx, 6);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.req_i = '0;
      bus.free_val_i = 1'b0;
      bus.free_code_i = '0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req_i = '0;
      bus.free_val_i = 1'b0;
      bus.free_code_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.gnt_o, bus.code_o, bus.free_err_o, bus.status_o, bus.full_o, bus.empty_o, bus.cnt_o} !==
          {4'b0, 6'd0, 1'b0, 18'h0, 1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL reset_state: gnt=%b code=%0d err=%b status=%h full=%b empty=%b cnt=%0d",
                  bus.gnt_o, bus.code_o, bus.free_err_o, bus.status_o, bus.full_o, bus.empty_o, bus.cnt_o);
      end
      rst = 1'b1;
   endtask

   task automatic test_single_grant();
      do_reset();
      bus.req_i = 4'b0001;
      push_exp(4'b0001, 1);
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL single_latency: gnt_o=%b one cycle after req, want 0001", bus.gnt_o);
      end
      bus.req_i = '0;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 4'b0 || bus.status_o !== 18'h00001 || bus.cnt_o !== 5'd1 || bus.empty_o !== 1'b0) begin
         errors++;
         $display("FAIL single_after: gnt=%b status=%h cnt=%0d empty=%b, want 0000 00001 1 0",
                  bus.gnt_o, bus.status_o, bus.cnt_o, bus.empty_o);
      end
   endtask

   task automatic test_back_to_back();
      int t[4];
      int n = 0;
      do_reset();
      for (int i = 0; i < 4; i++) push_exp(4'(1 << i), i + 1);
      bus.req_i = 4'b1111;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         if (|bus.gnt_o) begin
            t[n] = cyc;
            n++;
            bus.req_i = bus.req_i & ~bus.gnt_o;
         end
      end
      bus.req_i = '0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d grants, want 4", n);
      end
      for (int i = 1; i < n; i++) begin
         checks++;
         if (t[i] - t[i-1] != 2) begin
            errors++;
            $display("FAIL b2b_spacing: grant %0d came %0d cycles after previous, want 2", i, t[i] - t[i-1]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.status_o !== 18'h0000F || bus.cnt_o !== 5'd4) begin
         errors++;
         $display("FAIL b2b_status: status=%h cnt=%0d, want 0000f 4", bus.status_o, bus.cnt_o);
      end
   endtask

   task automatic test_full();
      int n = 0;
      do_reset();
      for (int k = 1; k <= N_CODES; k++) push_exp(4'b0001, k);
      bus.req_i = 4'b0001;
      for (int c = 0; c < 60 && n < N_CODES; c++) begin
         @(negedge clk);
         if (bus.gnt_o[0]) n++;
         if (n == N_CODES) bus.req_i = '0;
      end
      bus.req_i = '0;
      @(negedge clk);
      checks++;
      if (n != N_CODES || bus.full_o !== 1'b1 || bus.cnt_o !== 5'd18 || bus.status_o !== 18'h3FFFF) begin
         errors++;
         $display("FAIL full_fill: grants=%0d full=%b cnt=%0d status=%h, want 18 1 18 3ffff",
                  n, bus.full_o, bus.cnt_o, bus.status_o);
      end
      bus.req_i = 4'b0100;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== 4'b0) begin
            errors++;
            $display("FAIL full_hold: gnt_o=%b while full, want 0000", bus.gnt_o);
         end
      end
      push_exp(4'b0100, 7);
      bus.free_val_i = 1'b1;
      bus.free_code_i = 6'd7;
      @(negedge clk);
      bus.free_val_i = 1'b0;
      checks++;
      if (bus.full_o !== 1'b0 || bus.gnt_o !== 4'b0 || bus.cnt_o !== 5'd17) begin
         errors++;
         $display("FAIL full_release: full=%b gnt=%b cnt=%0d, want 0 0000 17", bus.full_o, bus.gnt_o, bus.cnt_o);
      end
      wait_grant(2, 4);
      @(negedge clk);
      checks++;
      if (bus.full_o !== 1'b1 || bus.cnt_o !== 5'd18) begin
         errors++;
         $display("FAIL full_regrant: full=%b cnt=%0d, want 1 18", bus.full_o, bus.cnt_o);
      end
   endtask

   task automatic test_bad_release();
      int bad[3] = '{0, 19, 5};
      do_reset();
      alloc(0, 1);
      alloc(0, 2);
      foreach (bad[i]) begin
         bus.free_val_i = 1'b1;
         bus.free_code_i = CODE_W'(bad[i]);
         @(negedge clk);
         bus.free_val_i = 1'b0;
         checks++;
         if (bus.free_err_o !== 1'b1 || bus.status_o !== 18'h00003) begin
            errors++;
            $display("FAIL bad_release_%0d: err=%b status=%h, want 1 00003", bad[i], bus.free_err_o, bus.status_o);
         end
         @(negedge clk);
         checks++;
         if (bus.free_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_%0d: err=%b a cycle later, want 0", bad[i], bus.free_err_o);
         end
      end
      bus.free_val_i = 1'b1;
      bus.free_code_i = 6'd2;
      @(negedge clk);
      bus.free_val_i = 1'b0;
      checks++;
      if (bus.free_err_o !== 1'b0 || bus.status_o !== 18'h00001 || bus.cnt_o !== 5'd1) begin
         errors++;
         $display("FAIL good_release: err=%b status=%h cnt=%0d, want 0 00001 1",
                  bus.free_err_o, bus.status_o, bus.cnt_o);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      alloc(0, 1);
      alloc(0, 2);
      bus.req_i[1] = 1'b1;
      push_exp(4'b0010, 3);
      wait_grant(1, 6);
      checks++;
      if (bus.status_o !== 18'h00003) begin
         errors++;
         $display("FAIL sim_before: status=%h, want 00003", bus.status_o);
      end
      bus.free_val_i = 1'b1;
      bus.free_code_i = 6'd1;
      @(negedge clk);
      bus.free_val_i = 1'b0;
      checks++;
      if (bus.status_o !== 18'h00006 || bus.cnt_o !== 5'd2 || bus.free_err_o !== 1'b0) begin
         errors++;
         $display("FAIL sim_after: status=%h cnt=%0d err=%b, want 00006 2 0",
                  bus.status_o, bus.cnt_o, bus.free_err_o);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      alloc(0, 1);
      bus.req_i[3] = 1'b1;
      push_exp(4'b1000, 2);
      wait_grant(3, 6);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0 || bus.status_o !== 18'h0 || bus.cnt_o !== 5'd0 || bus.empty_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: gnt=%b status=%h cnt=%0d empty=%b, want 0000 0 0 1",
                  bus.gnt_o, bus.status_o, bus.cnt_o, bus.empty_o);
      end
      @(negedge clk);
      exp_q.delete();
      rst = 1'b1;
      push_exp(4'b0001, 1);
      push_exp(4'b1000, 2);
      bus.req_i = 4'b1001;
      wait_grant(0, 4);
      wait_grant(3, 4);
      @(negedge clk);
      checks++;
      if (bus.status_o !== 18'h00003) begin
         errors++;
         $display("FAIL post_reset: status=%h, want 00003", bus.status_o);
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.req_i = '0;
      bus.free_val_i = 1'b0;
      bus.free_code_i = '0;
      test_reset();
      test_single_grant();
      test_back_to_back();
      test_full();
      test_bad_release();
      test_simultaneous();
      test_reset_mid_grant();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_grants: %0d expected grants never seen", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/code_pool_arbiter.md
Name: code_pool_arbiter

Overview:
- Shares the pool of N_CODES code slots (codes 1..N_CODES) between N_REQ requesters.
- Grants the lowest free code to a round-robin winner, accepts code releases and keeps the allocation mask as status_o.
- Sits in front of the code-selection datapath and is the single owner of code allocation state.

Parameters:
N_REQ, 4, number of requesters
N_CODES, 18, number of allocatable codes (valid codes 1..N_CODES)
CODE_W, 6, code width; must satisfy 2**CODE_W > N_CODES
CNT_W, $clog2(N_CODES+1), width of the allocated-count output

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
req_i  in  N_REQ  per-requester allocation request, level, held until granted
gnt_o  out  N_REQ  one-hot grant pulse, one cycle, registered
code_o  out  CODE_W  allocated code, valid only while |gnt_o, otherwise 0
free_val_i  in  1  release strobe
free_code_i  in  CODE_W  code to release
free_err_o  out  1  one-cycle pulse: invalid release rejected
status_o  out  N_CODES  bit k-1 set = code k allocated
full_o  out  1  all codes allocated
empty_o  out  1  no codes allocated
cnt_o  out  CNT_W  number of allocated codes (popcount of status_o)

Behaviour:
- Reset (rst_i=0, asynchronous) forces:
  - gnt_o=0, code_o=0, free_err_o=0
  - status_o=0, full_o=0, empty_o=1, cnt_o=0
  - round-robin pointer=0, FSM=IDLE
  - Reset mid-grant drops gnt_o immediately; the grant is lost and all allocations are cleared.
- FSM states: IDLE, GRANT.
- IDLE:
  - Grant condition: |req_i and not full_o.
    - Pick the winner: the first set bit of req_i at or above the pointer, wrapping.
    - Pick the code: the lowest k with status_o[k-1]=0, using the status_o value at that edge.
    - Register gnt_o[winner]=1 and code_o=k; go to GRANT.
  - No grant otherwise; remain in IDLE.
- GRANT (exactly one cycle):
  - gnt_o and code_o are visible for the whole cycle.
  - At the closing edge: set status_o[k-1], set pointer = (winner+1) mod N_REQ, clear gnt_o and code_o, go to IDLE.
- Timing:
  - Latency from req_i sampled in IDLE to gnt_o high is 1 cycle.
  - At most one grant every 2 cycles.
- Requester rule: deassert req_i on the edge where gnt_o is sampled high. req_i is ignored during GRANT. A requester holding req_i longer receives a further code on the next arbitration.
- Release, accepted in any state:
  - Valid when 1 <= free_code_i <= N_CODES and status_o[free_code_i-1]=1. The bit clears at the next edge.
  - Invalid when the code is 0, the code exceeds N_CODES, or the bit is already clear. free_err_o pulses for 1 cycle and status_o is unchanged.
- Simultaneous events:
  - A release and a grant-set on the same edge both apply; they never target the same bit, because the granted code was free.
  - A release in IDLE does not affect the same-edge code selection; the freed code is available from the next edge.
- Full:
  - Requests wait in IDLE with no timeout while full.
  - A release while full allows a grant decision on the following IDLE edge.
- Derived outputs full_o, empty_o and cnt_o:
  - Registered, updated on the same edge as status_o, consistent with it in every cycle.
  - Arithmetic is unsigned; cnt_o never exceeds N_CODES and never wraps.

Decomposition:
- Package code_sel_pkg holds N_CODES, CODE_W, CNT_W, typedef code_t (logic [CODE_W-1:0]), typedef mask_t (logic [N_CODES-1:0]), and the state enum {IDLE, GRANT}.
- One sub-module, rr_arbiter:
  - Parameterized by N_REQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner and its index.
  - Purely combinational.
- Lowest-free-code priority encoder and popcount stay inline in code_pool_arbiter.

Test Plan:
- Reset release; req_i=4'b0001 -> gnt_o=0001 one cycle later for 1 cycle, code_o=1; afterwards status_o=18'h00001, cnt_o=1, empty_o=0.
- req_i=4'b1111 held, requesters drop on grant -> grants in order 0,1,2,3 with codes 1,2,3,4 at 2-cycle spacing; status_o=18'h0000F.
- 18 grants issued, then req_i[2]=1 -> full_o=1, no gnt_o. Release code 7 -> next grant gives req 2 code 7, full_o returns to 1.
- Release code 0, then 19, then an already-free code 5 -> free_err_o pulses each time; status_o unchanged.
- Release code 1 on the same edge a grant of code 3 closes (codes 1,2 allocated) -> status_o goes from 18'h00003 to 18'h00006, cnt_o=2.
- rst_i low during GRANT -> gnt_o=0 and status_o=0 immediately; after release, the first grant goes to requester 0 with code 1.
